// File: rtl/multi_ch_door_ctrl_if.sv
// Panel/motor-side signal bundle for the multi-channel door controller.
// The controller takes the slave side; the panel/bench drives the master side.
interface multi_ch_door_ctrl_if #(
    parameter int unsigned N_CH = 2
);
    logic [N_CH-1:0]   press;
    logic [N_CH-1:0]   lim_open;
    logic [N_CH-1:0]   lim_closed;
    logic [N_CH-1:0]   fault_clr;
    logic [N_CH-1:0]   open_cw;
    logic [N_CH-1:0]   open_ccw;
    logic [N_CH-1:0]   fault;
    logic [3*N_CH-1:0] state_o;

    modport master (
        output press, lim_open, lim_closed, fault_clr,
        input  open_cw, open_ccw, fault, state_o
    );

    modport slave (
        input  press, lim_open, lim_closed, fault_clr,
        output open_cw, open_ccw, fault, state_o
    );
endinterface

// File: rtl/multi_ch_door_ctrl.sv
// N-channel single-button door motor controller: synchronised inputs, debounced press,
// limit-switch stop, run-time watchdog with latched fault, hold-to-run or toggle operation.
module multi_ch_door_ctrl #(
    parameter int unsigned N_CH         = 2,
    parameter int unsigned DEBOUNCE_CYC = 16,
    parameter int unsigned MAX_RUN_CYC  = 1000,
    parameter bit          HOLD_MODE    = 1'b1
) (
    input logic                 clk,
    input logic                 rst_n,
    multi_ch_door_ctrl_if.slave bus
);

    localparam int unsigned DbW  = $clog2(DEBOUNCE_CYC + 1);
    localparam int unsigned RunW = $clog2(MAX_RUN_CYC + 1);

    typedef enum logic [2:0] {
        StClosed = 3'd0,
        StRunCw  = 3'd1,
        StOpen   = 3'd2,
        StRunCcw = 3'd3,
        StFault  = 3'd4
    } state_e;

    logic [N_CH-1:0] press_s1, press_s2;
    logic [N_CH-1:0] lo_s1, lo_s2;
    logic [N_CH-1:0] lc_s1, lc_s2;

    logic [N_CH-1:0]   cw_vec, ccw_vec, flt_vec;
    logic [3*N_CH-1:0] st_vec;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            press_s1 <= '0;
            press_s2 <= '0;
            lo_s1    <= '0;
            lo_s2    <= '0;
            lc_s1    <= '0;
            lc_s2    <= '0;
        end else begin
            press_s1 <= bus.press;
            press_s2 <= press_s1;
            lo_s1    <= bus.lim_open;
            lo_s2    <= lo_s1;
            lc_s1    <= bus.lim_closed;
            lc_s2    <= lc_s1;
        end
    end

    for (genvar i = 0; i < N_CH; i++) begin : g_ch
        logic [DbW-1:0]  db_cnt_q;
        logic            press_db_q, press_db_prev_q;
        logic [RunW-1:0] run_cnt_q;
        state_e          st_q, st_d;
        logic            cw_q, ccw_q, flt_q;
        logic            rise, fall, stop_ev, timeout, in_run;

        assign rise    = press_db_q & ~press_db_prev_q;
        assign fall    = ~press_db_q & press_db_prev_q;
        assign stop_ev = HOLD_MODE ? fall : rise;
        assign timeout = (run_cnt_q == RunW'(MAX_RUN_CYC - 1));
        assign in_run  = (st_q == StRunCw) || (st_q == StRunCcw);

        always_comb begin
            st_d = st_q;
            case (st_q)
                StClosed: if (rise) st_d = lo_s2[i] ? StOpen : StRunCw;
                StRunCw: begin
                    if (lo_s2[i] || stop_ev) st_d = StOpen;
                    else if (timeout)        st_d = StFault;
                end
                StOpen:   if (rise) st_d = lc_s2[i] ? StClosed : StRunCcw;
                StRunCcw: begin
                    if (lc_s2[i] || stop_ev) st_d = StClosed;
                    else if (timeout)        st_d = StFault;
                end
                // Position is unknown after a fault; only a closed limit proves CLOSED.
                StFault:  if (bus.fault_clr[i]) st_d = lc_s2[i] ? StClosed : StOpen;
                default:  st_d = StClosed;
            endcase
        end

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                db_cnt_q        <= '0;
                press_db_q      <= 1'b0;
                press_db_prev_q <= 1'b0;
                run_cnt_q       <= '0;
                st_q            <= StClosed;
                cw_q            <= 1'b0;
                ccw_q           <= 1'b0;
                flt_q           <= 1'b0;
            end else begin
                press_db_prev_q <= press_db_q;
                if (press_s2[i] == press_db_q) begin
                    db_cnt_q <= '0;
                end else if (db_cnt_q == DbW'(DEBOUNCE_CYC - 1)) begin
                    db_cnt_q   <= '0;
                    press_db_q <= ~press_db_q;
                end else begin
                    db_cnt_q <= db_cnt_q + DbW'(1);
                end

                if (!in_run) begin
                    run_cnt_q <= '0;
                end else if (run_cnt_q != RunW'(MAX_RUN_CYC)) begin
                    run_cnt_q <= run_cnt_q + RunW'(1);
                end

                st_q  <= st_d;
                cw_q  <= (st_d == StRunCw);
                ccw_q <= (st_d == StRunCcw);
                flt_q <= (st_d == StFault);
            end
        end

        assign cw_vec[i]        = cw_q;
        assign ccw_vec[i]       = ccw_q;
        assign flt_vec[i]       = flt_q;
        assign st_vec[3*i +: 3] = st_q;
    end

    assign bus.open_cw  = cw_vec;
    assign bus.open_ccw = ccw_vec;
    assign bus.fault    = flt_vec;
    assign bus.state_o  = st_vec;

endmodule

// File: doc/multi_ch_door_ctrl.md
Name: multi_ch_door_ctrl

Overview:
- N-channel single-button door/gate motor controller, one independent FSM per channel.
- Each channel provides a debounced press input, limit-switch termination, a run-time watchdog with latched fault, and a hold-to-run or toggle mode.
- Drives per-channel CW (open) and CCW (close) motor enables; sits between the panel button inputs and the motor driver stage.
- Every channel is identical and shares clk and rst_n.

Parameters:
- N_CH, 2, number of independent channels (1..16).
- DEBOUNCE_CYC, 16, consecutive stable cycles required before the debounced press changes (>=1).
- MAX_RUN_CYC, 1000, maximum cycles a motor enable may stay high in one run before FAULT (>=2).
- HOLD_MODE, 1, 1 = motor runs only while the button is held; 0 = one press starts the run, the next press stops it.

Ports:
- clk  in  1  system clock.
- rst_n  in  1  reset.
- press  in  N_CH  raw, asynchronous button level per channel, active-high.
- lim_open  in  N_CH  fully-open limit switch, active-high, asynchronous.
- lim_closed  in  N_CH  fully-closed limit switch, active-high, asynchronous.
- fault_clr  in  N_CH  synchronous fault-clear request per channel.
- open_cw  out  N_CH  CW (opening) motor enable.
- open_ccw  out  N_CH  CCW (closing) motor enable.
- fault  out  N_CH  latched watchdog fault.
- state_o  out  3*N_CH  per-channel state code; channel i occupies bits [3i+2:3i].

Interface timing and reset:
- One clock; reset is asynchronous and active-low.
- Clock port is clk; reset port is rst_n.

Behaviour:
- Reset values (rst_n=0, applied asynchronously): all states CLOSED (0); open_cw=0, open_ccw=0, fault=0, state_o=0.
- Reset also clears synchronizers, debounce counters, debounced press, edge registers and run counters.
- Synchronization: press, lim_open and lim_closed each pass through a 2-flop synchronizer.
- Only press is debounced. The limit inputs are used straight after synchronization.
- Debounce: a per-channel counter runs while the synchronized press differs from press_db and clears whenever they are equal. When the counter reaches DEBOUNCE_CYC, press_db flips.
  - Pulses shorter than DEBOUNCE_CYC cycles are ignored.
  - rise = press_db 0->1; fall = press_db 1->0. Each is a single-cycle event.
- State codes: CLOSED=0, RUN_CW=1, OPEN=2, RUN_CCW=3, FAULT=4. Codes 5..7 are illegal and recover to CLOSED on the next edge.
- Transitions per channel, evaluated in priority order within each state:
  - CLOSED: rise with lim_open=1 -> OPEN; rise otherwise -> RUN_CW.
  - RUN_CW: lim_open -> OPEN; else stop-event -> OPEN; else timeout -> FAULT.
  - OPEN: rise with lim_closed=1 -> CLOSED; rise otherwise -> RUN_CCW.
  - RUN_CCW: lim_closed -> CLOSED; else stop-event -> CLOSED; else timeout -> FAULT.
  - FAULT: fault_clr=1 with lim_closed=1 -> CLOSED; fault_clr=1 otherwise -> OPEN (the door position is unknown and treated as open). press is ignored in FAULT.
- Stop-event: fall when HOLD_MODE=1; rise when HOLD_MODE=0 (in that mode fall is ignored).
- Run counter:
  - Cleared on every edge where the state is not RUN_CW or RUN_CCW; increments each cycle in a run state.
  - Width is clog2(MAX_RUN_CYC+1); the counter saturates and never wraps.
  - Timeout is asserted when the counter equals MAX_RUN_CYC-1, so the enable is high for exactly MAX_RUN_CYC cycles.
  - A limit or stop event in the same cycle as the timeout wins; no fault is raised.
- Outputs are Moore decodes of the registered state:
  - open_cw = (state==RUN_CW); open_ccw = (state==RUN_CCW); fault = (state==FAULT).
  - open_cw and open_ccw are never both 1.
  - There is no direct CW<->CCW reversal: a pass through OPEN or CLOSED of at least 1 cycle is guaranteed.
- Latency: press first sampled 1 at edge 1 -> press_db rises at edge 2+DEBOUNCE_CYC -> state changes and open_cw=1 after edge 3+DEBOUNCE_CYC. Limit input to motor-off takes 3 edges.
- Channels are fully independent; simultaneous events on different channels are all honoured in the same cycle.
- Reset asserted mid-run drops all motor enables immediately, without waiting for a clock edge.

Test Plan (N_CH=2, DEBOUNCE_CYC=4, MAX_RUN_CYC=20):
- Hold mode, ch0: press=1 for 12 cycles then 0 -> open_cw rises 7 edges after the first press sample; after release, state_o[2:0]=2 and open_cw=0. A second hold gives open_ccw=1, then state 0 on release.
- Glitch: 3-cycle press pulse on ch1 -> no state change, open_cw[1]=0 throughout.
- Limit: ch0 in RUN_CW, lim_open[0]=1 -> open_cw[0]=0 within 3 edges, state=2. Press with lim_open high from CLOSED -> straight to OPEN, open_cw never asserted.
- Watchdog: hold ch0 for 40 cycles -> open_cw high exactly 20 cycles, then fault[0]=1, state=4. Press is ignored; fault_clr[0]=1 with lim_closed[0]=0 -> state=2, fault=0.
- Toggle mode (HOLD_MODE=0): rise starts RUN_CW, release ignored, second rise -> OPEN. Simultaneous ch0 limit and ch1 press: both handled in the same cycle.
- Reset: rst_n=0 asynchronously mid-RUN_CCW -> open_ccw=0 before the next clk edge, all outputs 0. Release reset -> state CLOSED.
